// File: rtl/bellek_islem_birimi.sv
// Memory access unit sitting after the execute stage (yurut).
// Accepts one load/store from yurut, runs it on the data-memory
// request/response bus, stalls yurut until it finishes and hands back the
// raw 32-bit read word. A bounded timeout turns a silent bus into an error pulse.
module bellek_islem_birimi #(
  parameter int ZAMAN_ASIMI = 256,
  parameter int SAYAC_BIT   = 9
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        bib_sec_i,
  input  logic        bib_yaz_gecerli_i,
  input  logic [31:0] bib_adr_i,
  input  logic [31:0] bib_veri_i,
  input  logic [3:0]  bib_veri_maske_i,
  output logic [31:0] bib_veri_o,
  output logic        bib_durdur_o,
  output logic        bib_hata_o,
  output logic        l1v_istek_gecerli_o,
  input  logic        l1v_istek_hazir_i,
  output logic [31:0] l1v_istek_adr_o,
  output logic [31:0] l1v_istek_veri_o,
  output logic [3:0]  l1v_istek_maske_o,
  output logic        l1v_istek_yaz_o,
  input  logic        l1v_yanit_gecerli_i,
  input  logic [31:0] l1v_yanit_veri_i
);

  typedef enum logic [1:0] {BOSTA, ISTEK, BEKLE, TAMAM} durum_t;

  durum_t               durum;
  logic [SAYAC_BIT-1:0] sayac;
  logic [31:0]          adr_r;
  logic [31:0]          veri_r;
  logic [3:0]           maske_r;
  logic                 yaz_r;
  logic                 zaman_doldu;

  assign zaman_doldu = (sayac == SAYAC_BIT'(ZAMAN_ASIMI - 1));

  // Transaction FSM: latches the request, tracks the bus handshake and timeout,
  // and registers the read word and error pulse for the completion cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      durum      <= BOSTA;
      sayac      <= '0;
      adr_r      <= '0;
      veri_r     <= '0;
      maske_r    <= '0;
      yaz_r      <= 1'b0;
      bib_veri_o <= '0;
      bib_hata_o <= 1'b0;
    end else begin
      bib_hata_o <= 1'b0;
      case (durum)
        BOSTA: begin
          if (bib_sec_i) begin
            adr_r   <= bib_adr_i;
            veri_r  <= bib_veri_i;
            maske_r <= bib_yaz_gecerli_i ? bib_veri_maske_i : 4'hF;
            yaz_r   <= bib_yaz_gecerli_i;
            sayac   <= '0;
            durum   <= ISTEK;
          end
        end
        ISTEK: begin
          // Timeout wins over a same-cycle hazir so an abandoned request never
          // moves on to wait for a response.
          if (zaman_doldu) begin
            bib_veri_o <= '0;
            bib_hata_o <= 1'b1;
            durum      <= TAMAM;
          end else begin
            sayac <= sayac + 1'b1;
            if (l1v_istek_hazir_i) durum <= BEKLE;
          end
        end
        BEKLE: begin
          if (l1v_yanit_gecerli_i) begin
            bib_veri_o <= yaz_r ? '0 : l1v_yanit_veri_i;
            durum      <= TAMAM;
          end else if (zaman_doldu) begin
            bib_veri_o <= '0;
            bib_hata_o <= 1'b1;
            durum      <= TAMAM;
          end else begin
            sayac <= sayac + 1'b1;
          end
        end
        default: durum <= BOSTA;
      endcase
    end
  end

  assign l1v_istek_gecerli_o = (durum == ISTEK);
  assign l1v_istek_adr_o     = adr_r & 32'hFFFF_FFFC;
  assign l1v_istek_veri_o    = veri_r;
  assign l1v_istek_maske_o   = maske_r;
  assign l1v_istek_yaz_o     = yaz_r;

  // Stall is combinational so it asserts in the op's arrival cycle; held low
  // during reset so every output reads 0 while rst_i is asserted.
  assign bib_durdur_o = rst_i & bib_sec_i & (durum != TAMAM);

endmodule

// File: tb/tb_bellek_islem_birimi.sv
// Bench for bellek_islem_birimi: yurut-side driver plus bus responder, with a
// per-transaction reference model built from bus wait counts.
module tb_bellek_islem_birimi;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        sec = 1'b0, yaz = 1'b0;
  logic [31:0] adr = '0, veri = '0;
  logic [3:0]  maske = '0;
  logic        hazir = 1'b0, yanit = 1'b0;
  logic [31:0] yanit_veri = '0;

  logic [31:0] veri_o;
  logic        durdur_o, hata_o, gecerli_o, ist_yaz_o;
  logic [31:0] ist_adr_o, ist_veri_o;
  logic [3:0]  ist_maske_o;

  bellek_islem_birimi #(.ZAMAN_ASIMI(N), .SAYAC_BIT(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .bib_sec_i(sec), .bib_yaz_gecerli_i(yaz), .bib_adr_i(adr),
    .bib_veri_i(veri), .bib_veri_maske_i(maske),
    .bib_veri_o(veri_o), .bib_durdur_o(durdur_o), .bib_hata_o(hata_o),
    .l1v_istek_gecerli_o(gecerli_o), .l1v_istek_hazir_i(hazir),
    .l1v_istek_adr_o(ist_adr_o), .l1v_istek_veri_o(ist_veri_o),
    .l1v_istek_maske_o(ist_maske_o), .l1v_istek_yaz_o(ist_yaz_o),
    .l1v_yanit_gecerli_i(yanit), .l1v_yanit_veri_i(yanit_veri)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  // Observations from the last transaction
  int          obs_stall, obs_first, obs_hs;
  logic [31:0] obs_veri, obs_adr, obs_sveri;
  logic [3:0]  obs_maske;
  logic        obs_hata, obs_yaz, obs_unstable, obs_hung;

  typedef struct packed {
    int          stall;
    logic [31:0] veri;
    logic        hata;
    logic [31:0] adr;
    logic [3:0]  maske;
  } exp_t;

  // Reference: the op spends (hw+1) cycles requesting and (yw+1) waiting;
  // if that exceeds N bus cycles it times out after exactly N.
  function automatic exp_t model(input logic y, input logic [31:0] a, input logic [3:0] m,
                                 input int hw, input int yw, input logic [31:0] rdata);
    exp_t e;
    int need;
    need    = (yw < 0) ? 1000 : (hw + 1) + (yw + 1);
    e.adr   = (a / 4) * 4;
    e.maske = y ? m : 4'hF;
    if (need <= N) begin
      e.stall = 1 + need;
      e.veri  = y ? 32'h0 : rdata;
      e.hata  = 1'b0;
    end else begin
      e.stall = 1 + N;
      e.veri  = 32'h0;
      e.hata  = 1'b1;
    end
    return e;
  endfunction

  // yurut driver + bus responder for one op; returns at negedge+1 of the TAMAM cycle
  task automatic run_op(input logic y, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] m, input int hw, input int yw, input logic [31:0] rdata);
    int  icnt, rcnt;
    bit  bekle, seen, done;
    icnt = 0; rcnt = 0; bekle = 0; seen = 0; done = 0;
    obs_first = -1; obs_hs = 0; obs_unstable = 0; obs_hung = 0; obs_stall = -1;
    @(negedge clk);
    sec = 1'b1; yaz = y; adr = a; veri = d; maske = m; yanit_veri = rdata;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc > 0) @(negedge clk);
      hazir = 1'b0; yanit = 1'b0;
      if (gecerli_o) begin
        if (!seen) begin
          seen = 1; obs_first = cyc;
          obs_adr = ist_adr_o; obs_maske = ist_maske_o; obs_sveri = ist_veri_o; obs_yaz = ist_yaz_o;
        end else if (ist_adr_o !== obs_adr || ist_maske_o !== obs_maske ||
                     ist_veri_o !== obs_sveri || ist_yaz_o !== obs_yaz) begin
          obs_unstable = 1;
        end
        if (icnt >= hw) begin hazir = 1'b1; bekle = 1; rcnt = 0; obs_hs++; end
        icnt++;
      end else if (bekle) begin
        if (yw >= 0 && rcnt == yw) begin yanit = 1'b1; bekle = 0; end
        rcnt++;
      end
      #1;
      if (!durdur_o) begin
        obs_stall = cyc; obs_veri = veri_o; obs_hata = hata_o; done = 1;
        break;
      end
    end
    hazir = 1'b0; yanit = 1'b0;
    if (!done) obs_hung = 1;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sec = 1'b0;
    end
  endtask

  task automatic test_reset;
    #3;
    vecs++;
    if ({veri_o, durdur_o, hata_o, gecerli_o, ist_adr_o, ist_veri_o, ist_maske_o, ist_yaz_o} !== '0) begin
      errs++;
      $display("FAIL reset_outputs: got veri=%h durdur=%b hata=%b gecerli=%b adr=%h iveri=%h maske=%h yaz=%b, need all 0",
               veri_o, durdur_o, hata_o, gecerli_o, ist_adr_o, ist_veri_o, ist_maske_o, ist_yaz_o);
    end
    @(negedge clk);
    rst_i = 1'b1;
  endtask

  task automatic test_load;
    exp_t e;
    e = model(1'b0, 32'h4000_0006, 4'h3, 0, 0, 32'hDEAD_BEEF);
    run_op(1'b0, 32'h4000_0006, 32'h1234_5678, 4'h3, 0, 0, 32'hDEAD_BEEF);
    vecs++;
    if (obs_adr !== e.adr || obs_maske !== e.maske || obs_yaz !== 1'b0) begin
      errs++;
      $display("FAIL load_fields: got adr=%h maske=%h yaz=%b, need adr=%h maske=%h yaz=0", obs_adr, obs_maske, obs_yaz, e.adr, e.maske);
    end
    vecs++;
    if (obs_hung || obs_stall != e.stall) begin
      errs++;
      $display("FAIL load_stall: got %0d stall cycles (hung=%0d), need %0d", obs_stall, obs_hung, e.stall);
    end
    vecs++;
    if (obs_veri !== e.veri || obs_hata !== e.hata) begin
      errs++;
      $display("FAIL load_result: got veri=%h hata=%b, need veri=%h hata=%b", obs_veri, obs_hata, e.veri, e.hata);
    end
  endtask

  task automatic test_idle(input logic [31:0] held);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      sec = 1'b0; yaz = 1'b1; adr = 32'hFFFF_FFFF;
      yanit = (i == 3);
      #1;
      vecs++;
      if (gecerli_o !== 1'b0 || durdur_o !== 1'b0 || hata_o !== 1'b0 || veri_o !== held) begin
        errs++;
        $display("FAIL idle_quiet: cycle %0d got gecerli=%b durdur=%b hata=%b veri=%h, need 0/0/0 veri=%h",
                 i, gecerli_o, durdur_o, hata_o, veri_o, held);
      end
    end
    yanit = 1'b0;
  endtask

  task automatic test_store;
    exp_t e;
    e = model(1'b1, 32'h0000_1002, 4'b0100, 5, 0, 32'h5555_AAAA);
    run_op(1'b1, 32'h0000_1002, 32'h00AB_0000, 4'b0100, 5, 0, 32'h5555_AAAA);
    vecs++;
    if (obs_adr !== e.adr || obs_maske !== e.maske || obs_sveri !== 32'h00AB_0000 || obs_yaz !== 1'b1 || obs_unstable) begin
      errs++;
      $display("FAIL store_fields: got adr=%h maske=%h veri=%h yaz=%b unstable=%0d, need adr=%h maske=%h veri=00ab0000 yaz=1 stable",
               obs_adr, obs_maske, obs_sveri, obs_yaz, obs_unstable, e.adr, e.maske);
    end
    vecs++;
    if (obs_hung || obs_stall != e.stall || obs_veri !== e.veri || obs_hata !== e.hata) begin
      errs++;
      $display("FAIL store_done: got stall=%0d veri=%h hata=%b, need stall=%0d veri=%h hata=%b",
               obs_stall, obs_veri, obs_hata, e.stall, e.veri, e.hata);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e1, e2;
    e1 = model(1'b0, 32'h8000_0010, 4'h0, 0, 0, 32'hCAFE_0001);
    run_op(1'b0, 32'h8000_0010, 32'h0, 4'h0, 0, 0, 32'hCAFE_0001);
    vecs++;
    if (obs_first != 1 || obs_hs != 1 || obs_stall != e1.stall || obs_veri !== e1.veri) begin
      errs++;
      $display("FAIL b2b_first: got first_req=%0d handshakes=%0d stall=%0d veri=%h, need 1/1/%0d/%h",
               obs_first, obs_hs, obs_stall, obs_veri, e1.stall, e1.veri);
    end
    e2 = model(1'b1, 32'h8000_0014, 4'hC, 0, 0, 32'hCAFE_0002);
    run_op(1'b1, 32'h8000_0014, 32'h1111_0000, 4'hC, 0, 0, 32'hCAFE_0002);
    vecs++;
    if (obs_first != 1 || obs_hs != 1 || obs_stall != e2.stall || obs_veri !== e2.veri ||
        obs_adr !== e2.adr || obs_maske !== e2.maske || obs_sveri !== 32'h1111_0000) begin
      errs++;
      $display("FAIL b2b_second: got first_req=%0d handshakes=%0d stall=%0d veri=%h adr=%h maske=%h, need 1/1/%0d/%h/%h/%h",
               obs_first, obs_hs, obs_stall, obs_veri, obs_adr, obs_maske, e2.stall, e2.veri, e2.adr, e2.maske);
    end
  endtask

  task automatic test_timeout;
    exp_t e;
    e = model(1'b0, 32'h0000_2000, 4'h0, 0, -1, 32'h7777_7777);
    run_op(1'b0, 32'h0000_2000, 32'h0, 4'h0, 0, -1, 32'h7777_7777);
    vecs++;
    if (obs_hung || obs_stall != e.stall || obs_hata !== 1'b1 || obs_veri !== 32'h0) begin
      errs++;
      $display("FAIL timeout: got stall=%0d hata=%b veri=%h, need stall=%0d hata=1 veri=0", obs_stall, obs_hata, obs_veri, e.stall);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sec = 1'b0; yanit = 1'b1; yanit_veri = 32'h7777_7777;
      #1;
      vecs++;
      if (hata_o !== 1'b0 || gecerli_o !== 1'b0 || veri_o !== 32'h0) begin
        errs++;
        $display("FAIL late_response: got hata=%b gecerli=%b veri=%h, need 0/0/0", hata_o, gecerli_o, veri_o);
      end
    end
    yanit = 1'b0;
  endtask

  task automatic test_async_reset;
    exp_t e;
    run_op(1'b0, 32'h0000_3000, 32'h0, 4'h0, 0, 0, 32'hABCD_0123);
    @(negedge clk); sec = 1'b1; yaz = 1'b0; adr = 32'h0000_3004;
    @(negedge clk); hazir = gecerli_o;
    @(negedge clk); hazir = 1'b0;
    #2;
    rst_i = 1'b0;
    #1;
    vecs++;
    if ({veri_o, durdur_o, hata_o, gecerli_o, ist_adr_o, ist_maske_o} !== '0) begin
      errs++;
      $display("FAIL async_reset: got veri=%h durdur=%b hata=%b gecerli=%b adr=%h maske=%h, need all 0",
               veri_o, durdur_o, hata_o, gecerli_o, ist_adr_o, ist_maske_o);
    end
    sec = 1'b0;
    @(negedge clk); rst_i = 1'b1;
    e = model(1'b0, 32'h0000_3008, 4'h0, 1, 2, 32'h0F0F_F0F0);
    run_op(1'b0, 32'h0000_3008, 32'h0, 4'h0, 1, 2, 32'h0F0F_F0F0);
    vecs++;
    if (obs_hung || obs_stall != e.stall || obs_veri !== e.veri || obs_hata !== e.hata || obs_adr !== e.adr) begin
      errs++;
      $display("FAIL after_reset_load: got stall=%0d veri=%h hata=%b adr=%h, need %0d/%h/%b/%h",
               obs_stall, obs_veri, obs_hata, obs_adr, e.stall, e.veri, e.hata, e.adr);
    end
  endtask

  task automatic test_random;
    exp_t        e;
    logic        y;
    logic [31:0] a, d, r;
    logic [3:0]  m;
    int          hw, yw;
    for (int k = 0; k < 40; k++) begin
      y  = 1'($urandom_range(0, 1));
      a  = $urandom; d = $urandom; r = $urandom;
      m  = 4'($urandom_range(1, 15));
      hw = int'($urandom_range(0, 5));
      yw = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 5));
      gap(int'($urandom_range(0, 2)));
      e = model(y, a, m, hw, yw, r);
      run_op(y, a, d, m, hw, yw, r);
      vecs++;
      if (obs_hung || obs_stall != e.stall || obs_veri !== e.veri || obs_hata !== e.hata ||
          obs_first != 1 || obs_adr !== e.adr || obs_maske !== e.maske || obs_yaz !== y ||
          (y && obs_sveri !== d) || obs_unstable || (!e.hata && obs_hs != 1)) begin
        errs++;
        $display("FAIL random_op %0d: got stall=%0d veri=%h hata=%b first=%0d adr=%h maske=%h yaz=%b sveri=%h unst=%0d hs=%0d, need stall=%0d veri=%h hata=%b first=1 adr=%h maske=%h yaz=%b sveri=%h",
                 k, obs_stall, obs_veri, obs_hata, obs_first, obs_adr, obs_maske, obs_yaz, obs_sveri, obs_unstable, obs_hs,
                 e.stall, e.veri, e.hata, e.adr, e.maske, y, d);
      end
    end
    gap(1);
  endtask

  initial begin
    test_reset;
    test_load;
    test_idle(32'hDEAD_BEEF);
    test_store;
    test_back_to_back;
    test_timeout;
    test_async_reset;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
